// File: rtl/note_player_pkg.sv
// Shared constants and FSM encodings for the note player voice controller.
package note_player_pkg;

   localparam int NOTE_W         = 6;
   localparam int DUR_W          = 6;
   localparam int STEP_W         = 20;
   localparam int SAMPLE_W       = 16;
   localparam int TIMEOUT_CYCLES = 8;
   localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [NOTE_W-1:0] NOTE_REST = '0;

   typedef enum logic {
      N_IDLE = 1'b0,
      N_PLAY = 1'b1
   } note_state_e;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_WAIT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/note_player_ctrl_freq_rom.sv
// Semitone phase-step table: step = round(f * 2^22 / 48000), note 49 = A4.
module freq_rom
   import note_player_pkg::*;
(
   input  logic [NOTE_W-1:0] note,
   output logic [STEP_W-1:0] step
);

   always_comb begin
      step = '0;
      case (note)
         6'd1:  step = 20'd2403;
         6'd2:  step = 20'd2546;
         6'd3:  step = 20'd2697;
         6'd4:  step = 20'd2858;
         6'd5:  step = 20'd3028;
         6'd6:  step = 20'd3208;
         6'd7:  step = 20'd3398;
         6'd8:  step = 20'd3600;
         6'd9:  step = 20'd3815;
         6'd10: step = 20'd4041;
         6'd11: step = 20'd4282;
         6'd12: step = 20'd4536;
         6'd13: step = 20'd4806;
         6'd14: step = 20'd5092;
         6'd15: step = 20'd5395;
         6'd16: step = 20'd5715;
         6'd17: step = 20'd6055;
         6'd18: step = 20'd6415;
         6'd19: step = 20'd6797;
         6'd20: step = 20'd7201;
         6'd21: step = 20'd7629;
         6'd22: step = 20'd8083;
         6'd23: step = 20'd8563;
         6'd24: step = 20'd9072;
         6'd25: step = 20'd9612;
         6'd26: step = 20'd10184;
         6'd27: step = 20'd10789;
         6'd28: step = 20'd11431;
         6'd29: step = 20'd12110;
         6'd30: step = 20'd12830;
         6'd31: step = 20'd13593;
         6'd32: step = 20'd14402;
         6'd33: step = 20'd15258;
         6'd34: step = 20'd16165;
         6'd35: step = 20'd17127;
         6'd36: step = 20'd18145;
         6'd37: step = 20'd19224;
         6'd38: step = 20'd20367;
         6'd39: step = 20'd21578;
         6'd40: step = 20'd22861;
         6'd41: step = 20'd24221;
         6'd42: step = 20'd25661;
         6'd43: step = 20'd27187;
         6'd44: step = 20'd28803;
         6'd45: step = 20'd30516;
         6'd46: step = 20'd32331;
         6'd47: step = 20'd34253;
         6'd48: step = 20'd36290;
         6'd49: step = 20'd38448;
         6'd50: step = 20'd40734;
         6'd51: step = 20'd43156;
         6'd52: step = 20'd45722;
         6'd53: step = 20'd48441;
         6'd54: step = 20'd51322;
         6'd55: step = 20'd54373;
         6'd56: step = 20'd57607;
         6'd57: step = 20'd61032;
         6'd58: step = 20'd64661;
         6'd59: step = 20'd68506;
         6'd60: step = 20'd72580;
         6'd61: step = 20'd76896;
         6'd62: step = 20'd81468;
         6'd63: step = 20'd86312;
         default: step = '0;
      endcase
   end

endmodule

// File: rtl/note_player_ctrl.sv
// Single-voice note player: note/duration FSM plus codec sample fetch FSM.
// Define NOTE_PLAYER_TIMEOUT_EN to add the sample_ready watchdog.
module note_player_ctrl
   import note_player_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                play_enable,
   input  logic                load_new_note,
   input  logic [NOTE_W-1:0]   note_to_load,
   input  logic [DUR_W-1:0]    duration_to_load,
   input  logic                beat,
   input  logic                sample_req,
   input  logic [SAMPLE_W-1:0] sine_sample,
   input  logic                sine_ready,
   output logic [STEP_W-1:0]   step_size,
   output logic                generate_next,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                sample_valid,
   output logic                done_with_note,
   output logic                busy,
   output logic                timeout_err
);

   note_state_e         note_state_q, note_state_d;
   logic [DUR_W-1:0]    remaining_q, remaining_d;
   logic [STEP_W-1:0]   step_size_q, step_size_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   fetch_state_e        fetch_state_q, fetch_state_d;
   logic                pending_q, pending_d;
   logic                gen_q, gen_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                valid_q, valid_d;

   logic [STEP_W-1:0]   rom_step;
   logic                playing;
   logic                tmo_hit;

   freq_rom u_freq_rom (
      .note (note_to_load),
      .step (rom_step)
   );

   assign playing = (note_state_q == N_PLAY) && play_enable;

   always_comb begin
      note_state_d = note_state_q;
      remaining_d  = remaining_q;
      step_size_d  = step_size_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      unique case (note_state_q)
         N_IDLE: begin
            if (load_new_note) begin
               if (duration_to_load == '0) begin
                  done_d = 1'b1;
               end else begin
                  note_state_d = N_PLAY;
                  remaining_d  = duration_to_load;
                  step_size_d  = rom_step;
                  busy_d       = 1'b1;
               end
            end
         end
         N_PLAY: begin
            // loads are ignored here, even alongside the final beat
            if (beat && play_enable) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == DUR_W'(1)) begin
                  note_state_d = N_IDLE;
                  step_size_d  = '0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end
            end
         end
         default: note_state_d = N_IDLE;
      endcase
   end

   always_comb begin
      fetch_state_d = fetch_state_q;
      pending_d     = pending_q;
      gen_d         = 1'b0;
      sample_d      = sample_q;
      valid_d       = 1'b0;
      unique case (fetch_state_q)
         F_IDLE: begin
            pending_d = 1'b0;
            if (sample_req || pending_q) begin
               if (playing) begin
                  gen_d         = 1'b1;
                  fetch_state_d = F_WAIT;
               end else begin
                  sample_d = '0;
                  valid_d  = 1'b1;
               end
            end
         end
         F_WAIT: begin
            if (sample_req) begin
               pending_d = 1'b1;
            end
            if (sine_ready) begin
               sample_d      = sine_sample;
               valid_d       = 1'b1;
               fetch_state_d = F_IDLE;
            end else if (tmo_hit) begin
               sample_d      = '0;
               valid_d       = 1'b1;
               fetch_state_d = F_IDLE;
            end
         end
         default: fetch_state_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         note_state_q  <= N_IDLE;
         remaining_q   <= '0;
         step_size_q   <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fetch_state_q <= F_IDLE;
         pending_q     <= 1'b0;
         gen_q         <= 1'b0;
         sample_q      <= '0;
         valid_q       <= 1'b0;
      end else begin
         note_state_q  <= note_state_d;
         remaining_q   <= remaining_d;
         step_size_q   <= step_size_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         fetch_state_q <= fetch_state_d;
         pending_q     <= pending_d;
         gen_q         <= gen_d;
         sample_q      <= sample_d;
         valid_q       <= valid_d;
      end
   end

`ifdef NOTE_PLAYER_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tmo_err_q, tmo_err_d;

   assign tmo_hit = (fetch_state_q == F_WAIT) && !sine_ready &&
                    (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = '0;
      tmo_err_d = tmo_err_q;
      if (tmo_hit) begin
         tmo_err_d = 1'b1;
      end else if (fetch_state_q == F_WAIT && !sine_ready) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign timeout_err = tmo_err_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign step_size      = step_size_q;
   assign generate_next  = gen_q;
   assign sample_out     = sample_q;
   assign sample_valid   = valid_q;
   assign done_with_note = done_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_note_player_ctrl.sv
// Self-checking bench for note_player_ctrl with a behavioural sine_reader responder.
module tb_note_player_ctrl;
   import note_player_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic                play_enable;
   logic                load_new_note;
   logic [NOTE_W-1:0]   note_to_load;
   logic [DUR_W-1:0]    duration_to_load;
   logic                beat;
   logic                sample_req;
   logic [SAMPLE_W-1:0] sine_sample;
   logic                sine_ready;
   logic [STEP_W-1:0]   step_size;
   logic                generate_next;
   logic [SAMPLE_W-1:0] sample_out;
   logic                sample_valid;
   logic                done_with_note;
   logic                busy;
   logic                timeout_err;

   int checks = 0;
   int errors = 0;

   bit rsp_en    = 1'b0;
   bit rsp_fixed = 1'b0;
   int rsp_lat   = 1;
   int rsp_cnt   = 0;
   logic [SAMPLE_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   note_player_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .play_enable      (play_enable),
      .load_new_note    (load_new_note),
      .note_to_load     (note_to_load),
      .duration_to_load (duration_to_load),
      .beat             (beat),
      .sample_req       (sample_req),
      .sine_sample      (sine_sample),
      .sine_ready       (sine_ready),
      .step_size        (step_size),
      .generate_next    (generate_next),
      .sample_out       (sample_out),
      .sample_valid     (sample_valid),
      .done_with_note   (done_with_note),
      .busy             (busy),
      .timeout_err      (timeout_err)
   );

   // sine_reader stand-in: answers generate_next after rsp_lat cycles
   initial begin
      sine_ready  = 1'b0;
      sine_sample = '0;
      forever begin
         @(posedge clk);
         #1;
         sine_ready = 1'b0;
         if (!rsp_en) rsp_cnt = 0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               sine_ready  = 1'b1;
               sine_sample = rsp_fixed ? 16'h1234 : SAMPLE_W'($urandom);
               exp_q.push_back(sine_sample);
            end
         end
         if (rsp_en && generate_next) rsp_cnt = rsp_lat;
      end
   end

   function automatic int model_step(int n);
      real f;
      if (n == 0) return 0;
      f = 440.0 * (2.0 ** (real'(n - 49) / 12.0));
      return $rtoi(f * 4194304.0 / 48000.0 + 0.5);
   endfunction

   task automatic cyc(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_note(int n, int d);
      load_new_note    = 1'b1;
      note_to_load     = NOTE_W'(n);
      duration_to_load = DUR_W'(d);
      cyc();
      load_new_note = 1'b0;
   endtask

   task automatic drain_note();
      play_enable = 1'b1;
      for (int i = 0; i < 80; i++) begin
         if (!busy) break;
         beat = 1'b1;
         cyc();
         beat = 1'b0;
      end
      cyc(4);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      reset = 1'b1;
      cyc(2);
      checks++;
      if ({step_size, generate_next, sample_out, sample_valid,
           done_with_note, busy, timeout_err} !== '0) begin
         errors++;
         $display("FAIL reset_held: got step=%0d gen=%b out=%h val=%b done=%b busy=%b terr=%b required all 0",
                  step_size, generate_next, sample_out, sample_valid,
                  done_with_note, busy, timeout_err);
      end
      reset = 1'b0;
      cyc(2);
      checks++;
      if ({step_size, generate_next, sample_out, sample_valid,
           done_with_note, busy, timeout_err} !== '0) begin
         errors++;
         $display("FAIL reset_released: got step=%0d busy=%b done=%b required 0",
                  step_size, busy, done_with_note);
      end
   endtask

   task automatic test_note_basic();
      play_enable = 1'b1;
      start_note(49, 3);
      checks++;
      if (step_size !== 20'd38448) begin
         errors++;
         $display("FAIL a4_step: got %0d required 38448", step_size);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL a4_busy: got %b required 1", busy);
      end
      for (int i = 1; i <= 3; i++) begin
         beat = 1'b1;
         cyc();
         beat = 1'b0;
         checks++;
         if (i < 3 && (done_with_note !== 1'b0 || busy !== 1'b1)) begin
            errors++;
            $display("FAIL a4_beat%0d: got done=%b busy=%b required 0/1", i, done_with_note, busy);
         end else if (i == 3 && {done_with_note, busy, step_size} !== {2'b10, 20'd0}) begin
            errors++;
            $display("FAIL a4_end: got done=%b busy=%b step=%0d required 1/0/0",
                     done_with_note, busy, step_size);
         end
      end
      cyc();
      checks++;
      if (done_with_note !== 1'b0) begin
         errors++;
         $display("FAIL a4_done_pulse: got %b required 0", done_with_note);
      end
   endtask

   task automatic test_fetch_timing();
      exp_q.delete();
      rsp_en    = 1'b1;
      rsp_lat   = 1;
      rsp_fixed = 1'b1;
      start_note(49, 20);
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b0;
      checks++;
      if (generate_next !== 1'b1) begin
         errors++;
         $display("FAIL fetch_gen_t1: got %b required 1", generate_next);
      end
      cyc();
      checks++;
      if ({generate_next, sample_valid} !== 2'b00) begin
         errors++;
         $display("FAIL fetch_t2: got gen=%b val=%b required 0/0", generate_next, sample_valid);
      end
      cyc();
      checks++;
      if (sample_valid !== 1'b1 || sample_out !== 16'h1234) begin
         errors++;
         $display("FAIL fetch_t3: got val=%b out=%h required 1/1234", sample_valid, sample_out);
      end
      cyc();
      checks++;
      if (sample_valid !== 1'b0 || sample_out !== 16'h1234) begin
         errors++;
         $display("FAIL fetch_hold: got val=%b out=%h required 0/1234", sample_valid, sample_out);
      end
      rsp_fixed = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_pending();
      int gens = 0;
      int vals = 0;
      logic [SAMPLE_W-1:0] e;
      exp_q.delete();
      rsp_lat = 1;
      for (int i = 0; i < 14; i++) begin
         sample_req = (i < 3);
         cyc();
         if (generate_next) gens++;
         if (sample_valid) begin
            vals++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            checks++;
            if (sample_out !== e) begin
               errors++;
               $display("FAIL pending_sample%0d: got %h required %h", vals, sample_out, e);
            end
         end
      end
      sample_req = 1'b0;
      checks++;
      if (gens != 2 || vals != 2) begin
         errors++;
         $display("FAIL pending_counts: got gen=%0d valid=%0d required 2/2", gens, vals);
      end
   endtask

   task automatic test_rest();
      drain_note();
      exp_q.delete();
      start_note(0, 2);
      checks++;
      if (step_size !== '0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rest_load: got step=%0d busy=%b required 0/1", step_size, busy);
      end
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b0;
      checks++;
      if (generate_next !== 1'b1) begin
         errors++;
         $display("FAIL rest_fetch: got gen=%b required 1", generate_next);
      end
      drain_note();
      exp_q.delete();
   endtask

   task automatic test_pause();
      play_enable = 1'b1;
      start_note(30, 2);
      play_enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat = 1'b1;
         cyc();
         beat = 1'b0;
         cyc();
      end
      checks++;
      if (busy !== 1'b1 || done_with_note !== 1'b0) begin
         errors++;
         $display("FAIL pause_beats: got busy=%b done=%b required 1/0", busy, done_with_note);
      end
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b0;
      checks++;
      if ({generate_next, sample_valid} !== 2'b01 || sample_out !== '0) begin
         errors++;
         $display("FAIL pause_req: got gen=%b val=%b out=%h required 0/1/0",
                  generate_next, sample_valid, sample_out);
      end
      play_enable = 1'b1;
      beat = 1'b1;
      cyc();
      beat = 1'b0;
      checks++;
      if (done_with_note !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pause_resume1: got done=%b busy=%b required 0/1", done_with_note, busy);
      end
      beat = 1'b1;
      cyc();
      beat = 1'b0;
      checks++;
      if (done_with_note !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL pause_resume2: got done=%b busy=%b required 1/0", done_with_note, busy);
      end
   endtask

   task automatic test_load_ignored();
      play_enable = 1'b1;
      start_note(49, 2);
      start_note(10, 5);
      checks++;
      if (step_size !== 20'd38448) begin
         errors++;
         $display("FAIL busy_load: got step=%0d required 38448", step_size);
      end
      beat = 1'b1;
      cyc();
      load_new_note    = 1'b1;
      note_to_load     = 6'd10;
      duration_to_load = 6'd1;
      cyc();
      beat          = 1'b0;
      load_new_note = 1'b0;
      checks++;
      if ({done_with_note, busy} !== 2'b10 || step_size !== '0) begin
         errors++;
         $display("FAIL final_beat_load: got done=%b busy=%b step=%0d required 1/0/0",
                  done_with_note, busy, step_size);
      end
      cyc();
      checks++;
      if (busy !== 1'b0 || step_size !== '0) begin
         errors++;
         $display("FAIL final_beat_after: got busy=%b step=%0d required 0/0", busy, step_size);
      end
      start_note(20, 0);
      checks++;
      if ({done_with_note, busy} !== 2'b10 || step_size !== '0) begin
         errors++;
         $display("FAIL dur0: got done=%b busy=%b step=%0d required 1/0/0",
                  done_with_note, busy, step_size);
      end
      cyc();
      checks++;
      if ({done_with_note, busy} !== 2'b00) begin
         errors++;
         $display("FAIL dur0_after: got done=%b busy=%b required 0/0", done_with_note, busy);
      end
   endtask

   task automatic test_freq_table();
      play_enable = 1'b1;
      for (int n = 0; n < 64; n++) begin
         start_note(n, 1);
         checks++;
         if (step_size !== STEP_W'(model_step(n))) begin
            errors++;
            $display("FAIL freq_note%0d: got %0d required %0d", n, step_size, model_step(n));
         end
         beat = 1'b1;
         cyc();
         beat = 1'b0;
         checks++;
         if ({done_with_note, busy} !== 2'b10) begin
            errors++;
            $display("FAIL freq_done%0d: got done=%b busy=%b required 1/0", n, done_with_note, busy);
         end
      end
   endtask

   task automatic test_random_notes();
      for (int it = 0; it < 20; it++) begin
         int n   = $urandom_range(0, 63);
         int d   = $urandom_range(1, 8);
         int rem = d;
         play_enable = 1'b1;
         start_note(n, d);
         for (int c = 0; c < 200 && rem != 0; c++) begin
            bit be = ($urandom_range(0, 1) == 1);
            bit pe = ($urandom_range(0, 3) != 0);
            bit ed;
            int es;
            beat             = be;
            play_enable      = pe;
            load_new_note    = ($urandom_range(0, 7) == 0);
            note_to_load     = NOTE_W'($urandom);
            duration_to_load = DUR_W'($urandom_range(1, 63));
            cyc();
            beat          = 1'b0;
            load_new_note = 1'b0;
            ed = be && pe && rem == 1;
            if (be && pe) rem--;
            es = (rem != 0) ? model_step(n) : 0;
            checks++;
            if (done_with_note !== ed || busy !== (rem != 0) || step_size !== STEP_W'(es)) begin
               errors++;
               $display("FAIL rnd_note%0d: got done=%b busy=%b step=%0d required %b/%b/%0d",
                        it, done_with_note, busy, step_size, ed, rem != 0, es);
            end
         end
         checks++;
         if (rem != 0) begin
            errors++;
            $display("FAIL rnd_note%0d_budget: got remaining=%0d required 0", it, rem);
         end
         play_enable = 1'b1;
         cyc();
      end
   endtask

   task automatic test_random_fetch();
      int outst = 0;
      int nreq  = 0;
      int nval  = 0;
      logic [SAMPLE_W-1:0] e;
      exp_q.delete();
      rsp_en = 1'b1;
      play_enable = 1'b1;
      start_note(49, 63);
      for (int c = 0; c < 400; c++) begin
         if (outst == 0 && c < 360 && $urandom_range(0, 2) == 0) begin
            bit pe = ($urandom_range(0, 3) != 0);
            play_enable = pe;
            rsp_lat     = $urandom_range(1, 3);
            sample_req  = 1'b1;
            if (!pe) exp_q.push_back('0);
            outst = 1;
            nreq++;
         end
         cyc();
         sample_req = 1'b0;
         if (sample_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            checks++;
            if (sample_out !== e) begin
               errors++;
               $display("FAIL rnd_fetch%0d: got %h required %h", nval, sample_out, e);
            end
            outst = 0;
            nval++;
         end
      end
      checks++;
      if (nval != nreq) begin
         errors++;
         $display("FAIL rnd_fetch_count: got %0d valids required %0d", nval, nreq);
      end
      play_enable = 1'b1;
   endtask

   task automatic test_end_during_fetch();
      int gens = 0;
      int vals = 0;
      logic [SAMPLE_W-1:0] got[2];
      logic [SAMPLE_W-1:0] first;
      drain_note();
      exp_q.delete();
      rsp_en  = 1'b1;
      rsp_lat = 3;
      start_note(49, 1);
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b1;
      beat       = 1'b1;
      cyc();
      sample_req = 1'b0;
      beat       = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (generate_next) gens++;
         if (sample_valid) begin
            if (vals < 2) got[vals] = sample_out;
            vals++;
         end
      end
      first = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      checks++;
      if (vals != 2 || gens != 0) begin
         errors++;
         $display("FAIL end_fetch_counts: got valid=%0d gen=%0d required 2/0", vals, gens);
      end
      checks++;
      if (got[0] !== first || got[1] !== '0) begin
         errors++;
         $display("FAIL end_fetch_values: got %h,%h required %h,0000", got[0], got[1], first);
      end
   endtask

`ifdef NOTE_PLAYER_TIMEOUT_EN
   task automatic test_timeout();
      int k = 0;
      rsp_en = 1'b0;
      play_enable = 1'b1;
      start_note(49, 5);
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (sample_valid) begin
            k = i;
            break;
         end
      end
      checks++;
      if (k != 8 || sample_out !== '0 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout: got latency=%0d out=%h terr=%b required 8/0/1",
                  k, sample_out, timeout_err);
      end
      cyc(3);
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: got %b required 1", timeout_err);
      end
   endtask
`else
   task automatic test_timeout();
      int vals = 0;
      rsp_en = 1'b0;
      play_enable = 1'b1;
      start_note(49, 5);
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (sample_valid) vals++;
      end
      checks++;
      if (vals != 0 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout: got valid=%0d terr=%b required 0/0", vals, timeout_err);
      end
   endtask
`endif

   task automatic test_reset_mid_fetch();
      rsp_en = 1'b0;
      reset  = 1'b1;
      cyc();
      reset  = 1'b0;
      cyc();
      play_enable = 1'b1;
      start_note(49, 5);
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b0;
      checks++;
      if (generate_next !== 1'b1) begin
         errors++;
         $display("FAIL rst_setup_gen: got %b required 1", generate_next);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({step_size, generate_next, sample_out, sample_valid,
           done_with_note, busy, timeout_err} !== '0) begin
         errors++;
         $display("FAIL reset_async: got step=%0d gen=%b busy=%b required 0",
                  step_size, generate_next, busy);
      end
      cyc();
      reset = 1'b0;
      cyc();
      sample_req = 1'b1;
      cyc();
      sample_req = 1'b0;
      checks++;
      if ({generate_next, sample_valid, busy} !== 3'b010 || sample_out !== '0) begin
         errors++;
         $display("FAIL reset_idle_fsm: got gen=%b val=%b busy=%b out=%h required 0/1/0/0",
                  generate_next, sample_valid, busy, sample_out);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b0;
      play_enable      = 1'b0;
      load_new_note    = 1'b0;
      note_to_load     = '0;
      duration_to_load = '0;
      beat             = 1'b0;
      sample_req       = 1'b0;
      test_reset();
      test_note_basic();
      test_fetch_timing();
      test_pending();
      test_rest();
      test_pause();
      test_load_ignored();
      test_freq_table();
      test_random_notes();
      test_random_fetch();
      test_end_during_fetch();
      test_timeout();
      test_reset_mid_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
